// File: rtl/fsm_err_monitor.sv
// Error monitor for an upstream FSM stage: decodes its status code, counts err rising edges
// and raises a sticky alarm on persistent err. Build option: ILLEGAL_ALARM_EN (illegal codes alarm).
module fsm_err_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ALARM_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             o1,
  input  logic             o2,
  input  logic             err,
  input  logic             clr,
  output logic [1:0]       up_state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             alarm,
  output logic             illegal
);

  localparam int unsigned RUN_W = $clog2(ALARM_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(ALARM_LEN);

  localparam logic [1:0] MON_OK    = 2'b00;
  localparam logic [1:0] MON_FAULT = 2'b01;
  localparam logic [1:0] MON_ALARM = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       up_q, up_d;
  logic             err_d_q;
  logic             pulse_q, pulse_d;
  logic             alarm_q, alarm_d;
  logic             ill_q;
  logic             ill_c;
  logic             rise_c;
  logic             ev_c;

  // Status code decode; anything outside the four legal codes reads as IDLE plus illegal.
  always_comb begin
    up_d  = 2'b00;
    ill_c = 1'b0;
    case ({o1, o2, err})
      3'b000:  up_d = 2'b00;
      3'b100:  up_d = 2'b01;
      3'b010:  up_d = 2'b10;
      3'b111:  up_d = 2'b11;
      default: ill_c = 1'b1;
    endcase
  end

  assign rise_c = err & ~err_d_q;

`ifdef ILLEGAL_ALARM_EN
  assign ev_c = rise_c | ill_c;
`else
  assign ev_c = rise_c;
`endif

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    pulse_d = rise_c & ~clr;
    if (clr || !err) begin
      run_d = '0;
    end else if (rise_c) begin
      run_d = RUN_W'(1);
    end else if (run_q < RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
    if (clr) begin
      cnt_d = '0;
    end else if (ev_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Next state; OK leaves on any err=1 so a run that survives a clr can still reach alarm.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MON_OK: begin
        if (err) state_d = (run_d == RUN_MAX) ? MON_ALARM : MON_FAULT;
      end
      MON_FAULT: begin
        if (!err)                 state_d = MON_OK;
        else if (run_d == RUN_MAX) state_d = MON_ALARM;
      end
      MON_ALARM: state_d = MON_ALARM;
      default:   state_d = MON_OK;
    endcase
`ifdef ILLEGAL_ALARM_EN
    if (ill_c) state_d = MON_ALARM;
`endif
    if (clr) state_d = MON_OK;
    alarm_d = (state_d == MON_ALARM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MON_OK;
      run_q   <= '0;
      cnt_q   <= '0;
      up_q    <= 2'b00;
      err_d_q <= 1'b0;
      pulse_q <= 1'b0;
      alarm_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      err_d_q <= err;
      pulse_q <= pulse_d;
      alarm_q <= alarm_d;
      ill_q   <= ill_c;
    end
  end

  assign up_state  = up_q;
  assign err_pulse = pulse_q;
  assign err_cnt   = cnt_q;
  assign alarm     = alarm_q;
  assign illegal   = ill_q;

endmodule
